// File: rtl/cnn_image_loader.sv
// cnn_image_loader: assembles a ROWS x COLS pixel stream into the flat CNN image bus and runs the core.
// Optional macro CNN_LOADER_PINGPONG_EN adds a shadow bank that fills while the core runs.
module cnn_image_loader #(
  parameter int ROWS  = 30,
  parameter int COLS  = 10,
  parameter int PIX_W = 8
) (
  input  logic                          clk,
  input  logic                          rst_b,
  input  logic                          s_valid,
  input  logic [PIX_W-1:0]              s_data,
  input  logic                          s_last,
  output logic                          s_ready,
  input  logic                          cnn_done,
  output logic [0:ROWS*COLS*PIX_W-1]    mem,
  output logic                          en,
  output logic                          busy,
  output logic                          frame_err,
  output logic [7:0]                    frame_cnt
);
  localparam int NPIX = ROWS * COLS;
  localparam int CW   = $clog2(NPIX);
  localparam logic [CW-1:0] LAST_IDX = CW'(NPIX - 1);

  typedef enum logic [1:0] {LOAD = 2'd0, RUN = 2'd1, GAP = 2'd2} state_t;

  state_t                state;
  logic [CW-1:0]         pix_cnt;
  logic [0:NPIX*PIX_W-1] bank0;
  logic                  accept;
  logic                  at_end;
  logic                  good_end;

  assign accept   = s_valid && s_ready;
  assign at_end   = (pix_cnt == LAST_IDX);
  assign good_end = accept && at_end && s_last;

`ifdef CNN_LOADER_PINGPONG_EN
  logic [0:NPIX*PIX_W-1] bank1;
  logic                  active;
  logic                  shadow_full;
  logic                  wr_sel;

  // Beats fill the active bank while loading and the shadow bank while the core runs.
  assign wr_sel = (state == LOAD) ? active : ~active;
  assign mem    = active ? bank1 : bank0;
`else
  assign mem = bank0;
`endif

  always_ff @(posedge clk) begin
    if (rst_b) begin
      pix_cnt   <= '0;
      frame_err <= 1'b0;
      bank0     <= '0;
`ifdef CNN_LOADER_PINGPONG_EN
      bank1     <= '0;
`endif
    end else begin
      frame_err <= 1'b0;
      if (accept) begin
`ifdef CNN_LOADER_PINGPONG_EN
        if (wr_sel) bank1[int'(pix_cnt)*PIX_W +: PIX_W] <= s_data;
        else        bank0[int'(pix_cnt)*PIX_W +: PIX_W] <= s_data;
`else
        bank0[int'(pix_cnt)*PIX_W +: PIX_W] <= s_data;
`endif
        // Any frame boundary restarts the count; a boundary without both marks is an error.
        if (at_end || s_last) begin
          pix_cnt   <= '0;
          frame_err <= at_end ^ s_last;
        end else begin
          pix_cnt <= pix_cnt + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst_b) begin
      state     <= LOAD;
      en        <= 1'b0;
      busy      <= 1'b0;
      s_ready   <= 1'b0;
      frame_cnt <= 8'd0;
`ifdef CNN_LOADER_PINGPONG_EN
      active      <= 1'b0;
      shadow_full <= 1'b0;
`endif
    end else begin
      case (state)
        LOAD: begin
          if (good_end) begin
            state <= RUN;
            en    <= 1'b1;
            busy  <= 1'b1;
`ifdef CNN_LOADER_PINGPONG_EN
            s_ready <= 1'b1;
`else
            s_ready <= 1'b0;
`endif
          end else begin
            s_ready <= 1'b1;
          end
        end
        RUN: begin
`ifdef CNN_LOADER_PINGPONG_EN
          if (cnn_done) begin
            frame_cnt <= frame_cnt + 8'd1;
            en        <= 1'b0;
            active    <= ~active;
            s_ready   <= 1'b1;
            // A shadow frame finishing this same cycle still qualifies for back-to-back.
            if (shadow_full || good_end) begin
              shadow_full <= 1'b0;
              state       <= GAP;
            end else begin
              state <= LOAD;
              busy  <= 1'b0;
            end
          end else if (good_end) begin
            shadow_full <= 1'b1;
            s_ready     <= 1'b0;
          end
`else
          if (cnn_done) begin
            state     <= LOAD;
            en        <= 1'b0;
            busy      <= 1'b0;
            s_ready   <= 1'b1;
            frame_cnt <= frame_cnt + 8'd1;
          end
`endif
        end
`ifdef CNN_LOADER_PINGPONG_EN
        GAP: begin
          state <= RUN;
          en    <= 1'b1;
          if (good_end) begin
            shadow_full <= 1'b1;
            s_ready     <= 1'b0;
          end
        end
`endif
        default: begin
          state   <= LOAD;
          en      <= 1'b0;
          busy    <= 1'b0;
          s_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cnn_image_loader.sv
// Scoreboard bench for cnn_image_loader: stimulus queues expected en/frame_err events, a monitor checks them.
module tb_cnn_image_loader;
  localparam int NPIX = 300;
  localparam int W    = NPIX * 8;
  localparam int EV_RISE = 1;
  localparam int EV_FALL = 2;
  localparam int EV_ERR  = 3;

  logic         clk = 1'b0;
  logic         rst_b, s_valid, s_last, s_ready, cnn_done, en, busy, frame_err;
  logic [7:0]   s_data, frame_cnt;
  logic [0:W-1] mem;

  always #5 clk = ~clk;

  cnn_image_loader dut (
    .clk(clk), .rst_b(rst_b), .s_valid(s_valid), .s_data(s_data), .s_last(s_last),
    .s_ready(s_ready), .cnn_done(cnn_done), .mem(mem), .en(en), .busy(busy),
    .frame_err(frame_err), .frame_cnt(frame_cnt)
  );

  typedef struct {
    int           kind;
    logic [7:0]   cnt;
    logic [0:W-1] img;
  } ev_t;

  ev_t          q[$];
  int           n_chk  = 0;
  int           n_pass = 0;
  logic         en_q   = 1'b0;
  logic [0:W-1] exp_img, tmp_img, zero_img;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
  endtask

  task automatic chk_img(input string name, input logic [0:W-1] got, input logic [0:W-1] exp);
    int bad;
    bad = -1;
    for (int k = NPIX - 1; k >= 0; k--)
      if (got[k*8 +: 8] !== exp[k*8 +: 8]) bad = k;
    n_chk++;
    if (bad < 0) n_pass++;
    else $display("FAIL %s: pixel %0d got 0x%0h, expected 0x%0h", name, bad, got[bad*8 +: 8], exp[bad*8 +: 8]);
  endtask

  task automatic push_ev(input int kind, input logic [7:0] cnt, input logic [0:W-1] img);
    ev_t e;
    e.kind = kind;
    e.cnt  = cnt;
    e.img  = img;
    q.push_back(e);
  endtask

  task automatic take(input int kind);
    ev_t e;
    if (q.size() == 0) begin
      n_chk++;
      $display("FAIL unexpected_event: got kind %0d, expected none", kind);
    end else begin
      e = q.pop_front();
      chk("event_kind", kind, e.kind);
      chk("event_frame_cnt", frame_cnt, e.cnt);
      if (kind != EV_ERR) chk_img("event_mem", mem, e.img);
      if (kind == EV_RISE) chk("rise_s_ready", s_ready, 0);
      if (kind == EV_ERR) chk("err_en", en, 0);
    end
  endtask

  // monitor: en edges and frame_err pulses are popped against the scoreboard
  always @(negedge clk) begin
    if (frame_err === 1'b1) take(EV_ERR);
    if (en === 1'b1 && en_q === 1'b0) take(EV_RISE);
    if (en === 1'b0 && en_q === 1'b1) take(EV_FALL);
    en_q = en;
  end

  task automatic send(input logic [7:0] d, input logic l);
    logic acc;
    s_valid = 1'b1;
    s_data  = d;
    s_last  = l;
    acc     = 1'b0;
    for (int t = 0; t < 20 && !acc; t++) begin
      acc = s_ready;
      @(posedge clk);
      #1;
    end
    if (!acc) begin
      n_chk++;
      $display("FAIL send_timeout: s_ready 0, expected 1");
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic send_seq(input logic [0:W-1] img, input int n, input int last_at);
    for (int k = 0; k < n; k++) send(img[k*8 +: 8], k == last_at);
  endtask

  task automatic pulse_done();
    cnn_done = 1'b1;
    @(posedge clk);
    #1;
    cnn_done = 1'b0;
  endtask

  initial begin
    rst_b = 1'b1; s_valid = 1'b0; s_data = 8'd0; s_last = 1'b0; cnn_done = 1'b0;
    zero_img = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_b = 1'b0;
    chk("reset_en", en, 0);
    chk("reset_busy", busy, 0);
    chk("reset_frame_err", frame_err, 0);
    chk("reset_frame_cnt", frame_cnt, 0);
    chk("reset_s_ready", s_ready, 0);
    chk_img("reset_mem", mem, zero_img);
    @(posedge clk);
    #1;
    chk("post_reset_s_ready", s_ready, 1);

    // frame 0: pixel k = k & 0xFF
    for (int k = 0; k < NPIX; k++) exp_img[k*8 +: 8] = 8'(k);
    push_ev(EV_RISE, 8'd0, exp_img);
    send_seq(exp_img, NPIX, NPIX - 1);
    chk("run_en", en, 1);
    chk("run_busy", busy, 1);
    chk("run_s_ready", s_ready, 0);
    chk("pix0", mem[0 +: 8], 8'h00);
    chk("pix299", mem[2392 +: 8], 8'h2B);

    // beats offered during RUN must be ignored
    s_valid = 1'b1;
    s_data  = 8'hAA;
    repeat (20) @(posedge clk);
    #1;
    s_valid = 1'b0;
    chk("hold_s_ready", s_ready, 0);
    chk_img("hold_mem", mem, exp_img);
    push_ev(EV_FALL, 8'd1, exp_img);
    pulse_done();
    chk("done_en", en, 0);
    chk("done_s_ready", s_ready, 1);
    chk("done_frame_cnt", frame_cnt, 1);

    // early s_last on beat 100
    for (int k = 0; k < 100; k++) tmp_img[k*8 +: 8] = 8'hC0 ^ 8'(k);
    push_ev(EV_ERR, 8'd1, zero_img);
    send_seq(tmp_img, 100, 99);
    chk("early_en", en, 0);
    chk("early_pix99", mem[99*8 +: 8], 8'hA3);
    chk("early_pix_cnt", dut.pix_cnt, 0);
    for (int k = 0; k < NPIX; k++) exp_img[k*8 +: 8] = 8'(k * 3);
    push_ev(EV_RISE, 8'd1, exp_img);
    send_seq(exp_img, NPIX, NPIX - 1);
    chk("reload_en", en, 1);
    push_ev(EV_FALL, 8'd2, exp_img);
    pulse_done();
    chk("done2_frame_cnt", frame_cnt, 2);

    // 300 beats without s_last
    for (int k = 0; k < NPIX; k++) tmp_img[k*8 +: 8] = 8'h10 + 8'(k);
    push_ev(EV_ERR, 8'd2, zero_img);
    send_seq(tmp_img, NPIX, -1);
    chk("missing_en", en, 0);
    chk("missing_busy", busy, 0);
    chk("missing_pix_cnt", dut.pix_cnt, 0);
    chk("missing_pix299", mem[2392 +: 8], 8'h3B);

    // load a frame, then reset in the middle of its run
    for (int k = 0; k < NPIX; k++) exp_img[k*8 +: 8] = 8'hFF - 8'(k);
    push_ev(EV_RISE, 8'd2, exp_img);
    send_seq(exp_img, NPIX, NPIX - 1);
    chk("pre_reset_en", en, 1);
    push_ev(EV_FALL, 8'd0, zero_img);
    rst_b = 1'b1;
    @(posedge clk);
    #1;
    rst_b = 1'b0;
    chk("midrst_en", en, 0);
    chk("midrst_frame_cnt", frame_cnt, 0);
    chk_img("midrst_mem", mem, zero_img);
    pulse_done();
    chk("idle_done_en", en, 0);
    chk("idle_done_frame_cnt", frame_cnt, 0);
    chk("idle_done_busy", busy, 0);

    repeat (3) @(posedge clk);
    #1;
    chk("queue_drained", q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/cnn_image_loader.md
Name: cnn_image_loader

Overview:
Writer side of the CNN image-buffer interface. Accepts a byte stream of pixels over a valid/ready handshake and assembles one 30x10 8-bit frame into the flat image bus that the CNN core reads. When the frame is complete it raises the CNN enable and holds it until the core signals completion. Sits between the external pixel source and the CNN top; the CNN top itself contains no memory.

Parameters:
ROWS, 30, image rows
COLS, 10, image columns
PIX_W, 8, bits per pixel
NPIX, ROWS*COLS (derived, localparam), pixels per frame

Ports:
clk  in  1  clock, all logic on rising edge
rst_b  in  1  synchronous reset, ACTIVE-HIGH despite the suffix (codebase port name kept)
s_valid  in  1  pixel beat valid
s_data  in  PIX_W  pixel value
s_last  in  1  marks final pixel of frame
s_ready  out  1  loader can accept a beat
cnn_done  in  1  one-cycle pulse from the CNN top (tied to its valid) when the frame result is out
mem  out  [0:NPIX*PIX_W-1]  image bus to the CNN; pixel k occupies mem[k*PIX_W +: PIX_W], bit k*PIX_W is the MSB
en  out  1  CNN enable
busy  out  1  high in RUN
frame_err  out  1  one-cycle pulse on framing error
frame_cnt  out  8  completed-and-run frames, wraps 255->0

Behaviour:
- Beat accepted when s_valid && s_ready. The loader never depends on s_valid to drive s_ready.
- Pixel order: raster, k = row*COLS + col; first beat -> k=0.
- FSM states: LOAD, RUN.
- Reset (rst_b=1 at edge): state=LOAD, pix_cnt=0, mem=0, en=0, busy=0, s_ready=0 for the reset cycle then 1, frame_err=0, frame_cnt=0. Reset mid-RUN drops en on the next edge and discards the frame.
- LOAD: s_ready=1, en=0. Each accepted beat writes s_data to slot pix_cnt, then pix_cnt++.
  - Beat with pix_cnt=NPIX-1 and s_last=1: write, pix_cnt<=0, state<=RUN.
  - Beat with s_last=1 and pix_cnt<NPIX-1 (early last): frame_err pulse, pix_cnt<=0, stay LOAD. Written bytes stay in mem but are overwritten by the next frame.
  - Beat with pix_cnt=NPIX-1 and s_last=0 (missing last): frame_err pulse, pix_cnt<=0, stay LOAD.
- RUN: en=1 and busy=1 from the first cycle after the completing beat. s_ready=0, and mem is frozen for the whole of RUN.
  - On cnn_done: en<=0, frame_cnt++, state<=LOAD. s_ready=1 on the following cycle.
  - cnn_done in LOAD is ignored (no count, no error).
- Latency: completing beat at edge N; en=1 from edge N+1. cnn_done at edge M; en=0 and s_ready=1 from edge M+1.
- Between two runs, en is low for at least one cycle, so the CNN controller counters restart.

Optional Feature:
Macro: CNN_LOADER_PINGPONG_EN
- Defined:
  - Two frame banks. mem always drives the active bank.
  - During RUN, s_ready=1 and beats fill the shadow bank with the same framing and error rules.
  - A shadow frame completing is flagged shadow_full, and s_ready=0 until that frame is consumed.
  - On cnn_done with shadow_full=1: swap banks, clear shadow_full, drive en=0 for exactly one cycle, then en=1 with busy=1 (back-to-back run).
  - On cnn_done with shadow_full=0: go to LOAD as in the base design; loading continues into the (now active) shadow bank at the current pix_cnt.
  - If cnn_done and the shadow completing beat arrive in the same cycle, that counts as shadow_full=1.
- Undefined: single bank, behaviour exactly as above.

Test Plan:
- Reset then stream bytes k&8'hFF for k=0..299 with s_last on k=299 -> mem[0+:8]=0x00, mem[2392+:8]=0x2B; en=1 one cycle after the last beat; s_ready=0.
- During RUN, hold s_valid=1 with data 0xAA for 20 cycles, then pulse cnn_done -> mem unchanged; en=0 and s_ready=1 the next cycle; frame_cnt=1.
- s_last on the 100th beat (k=99) -> one frame_err pulse; en stays 0; the next 300-beat frame loads correctly from k=0.
- 300 beats with no s_last -> frame_err pulse on beat 300; pix_cnt=0; no RUN.
- Assert rst_b for 1 cycle mid-RUN -> en=0, mem=0, frame_cnt=0 next cycle; cnn_done afterwards has no effect.
- PINGPONG_EN: load frame A; during RUN load frame B (all 0x55); pulse cnn_done -> en low exactly 1 cycle, then mem=all 0x55 with en=1; frame_cnt=1.
